ga_chrom_fsm_exec: RTL and testbench

Synthesizable executor and scorer for GA chromosomes that encode a 3-state Mealy sequence detector. A 24-bit chromosome is loaded through a valid/ready handshake, then run bit-serially on an input stream, producing the detector output for each bit. Each output is compared against a supplied expected bit, and a weighted fitness score is accumulated using the same scoring rule as the GA fitness function. This block moves chromosome evaluation out of the behavioural GA loop and into hardware, so candidates can be scored on a real clock.

---
 rtl/ga_fsm_pkg.sv | 28 ++
 rtl/ga_gene_decode.sv | 30 +++
 rtl/ga_chrom_fsm_exec.sv | 129 ++++++++++++
 tb/tb_ga_chrom_fsm_exec.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_fsm_pkg.sv
// rtl/ga_fsm_pkg.sv - shared chromosome layout, control states and state reduction
// Chromosome: 2*NUM_STATES genes of GENE_W bits; gene e = state*2 + in_bit.
// Gene fields: [NS_MSB:NS_LSB] raw next state, [OUT_BIT] Mealy output.
package ga_fsm_pkg;

  localparam int NUM_STATES = 3;
  localparam int GENE_W     = 4;
  localparam int CHROM_W    = NUM_STATES * 2 * GENE_W;
  localparam int STATE_W    = 2;

  localparam int NS_LSB  = 0;
  localparam int NS_MSB  = 2;
  localparam int OUT_BIT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  // The raw next-state field can name up to 8 states; fold it onto the real ones.
  function automatic logic [STATE_W-1:0] mod_states(input logic [NS_MSB-NS_LSB:0] raw);
    logic [NS_MSB-NS_LSB:0] r;
    r = raw % 3'(NUM_STATES);
    return r[STATE_W-1:0];
  endfunction

endpackage

// File: rtl/ga_gene_decode.sv
// rtl/ga_gene_decode.sv - combinational gene lookup for one detector transition
// Ports: chrom (full chromosome), state (current detector state), in_bit (input)
//        -> next_state (already reduced to a legal state), out_bit (Mealy output).
module ga_gene_decode
  import ga_fsm_pkg::*;
(
  input  logic [CHROM_W-1:0] chrom,
  input  logic [STATE_W-1:0] state,
  input  logic               in_bit,
  output logic [STATE_W-1:0] next_state,
  output logic               out_bit
);

  logic [GENE_W-1:0] gene;

  // {state, in_bit} is state*2+in_bit; an illegal state selects no gene and
  // falls back to a zero gene (stay in state 0, output 0).
  always_comb begin
    gene = '0;
    for (int g = 0; g < 2 * NUM_STATES; g++) begin
      if (g == int'({state, in_bit})) begin
        gene = chrom[g*GENE_W +: GENE_W];
      end
    end
  end

  assign next_state = mod_states(gene[NS_MSB:NS_LSB]);
  assign out_bit    = gene[OUT_BIT];

endmodule

// File: rtl/ga_chrom_fsm_exec.sv
// rtl/ga_chrom_fsm_exec.sv - GA chromosome Mealy detector executor and scorer
// Ports: clk, rst_n (sync active-low)
//        chrom_valid/chrom_ready/chrom_data/seq_len : chromosome load handshake
//        in_valid/in_ready/in_bit/exp_bit           : input bit stream with expected output
//        out_valid/out_bit/out_state                 : per-bit detector result, 1-cycle latency
//        done                                        : one-cycle end-of-run pulse
//        score                                       : saturating fitness, held until next load
module ga_chrom_fsm_exec
  import ga_fsm_pkg::*;
#(
  parameter int SEQ_LEN_W   = 8,
  parameter int SCORE_W     = 12,
  parameter int HIT1_WEIGHT = 3,
  parameter int HIT0_WEIGHT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 chrom_valid,
  output logic                 chrom_ready,
  input  logic [CHROM_W-1:0]   chrom_data,
  input  logic [SEQ_LEN_W-1:0] seq_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_bit,
  input  logic                 exp_bit,
  output logic                 out_valid,
  output logic                 out_bit,
  output logic [STATE_W-1:0]   out_state,
  output logic                 done,
  output logic [SCORE_W-1:0]   score
);

  localparam logic [SCORE_W:0] W_HIT1 = (SCORE_W+1)'(HIT1_WEIGHT);
  localparam logic [SCORE_W:0] W_HIT0 = (SCORE_W+1)'(HIT0_WEIGHT);

  ctrl_state_t          ctrl, ctrl_nxt;
  logic [CHROM_W-1:0]   chrom_q;
  logic [SEQ_LEN_W-1:0] len_q;
  logic [SEQ_LEN_W-1:0] count;
  logic [STATE_W-1:0]   fsm_state;
  logic [STATE_W-1:0]   dec_state;
  logic                 dec_out;
  logic                 load;
  logic                 accept;
  logic                 last_bit;
  logic                 hit;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_upd;

  ga_gene_decode u_decode (
    .chrom      (chrom_q),
    .state      (fsm_state),
    .in_bit     (in_bit),
    .next_state (dec_state),
    .out_bit    (dec_out)
  );

  assign chrom_ready = (ctrl == IDLE);
  assign in_ready    = (ctrl == RUN);
  // DONE lasts exactly one cycle, so the pulse is simply the state decode.
  assign done        = (ctrl == DONE);

  assign load     = chrom_valid && chrom_ready;
  assign accept   = in_valid && in_ready;
  assign last_bit = (SEQ_LEN_W'(count + 1'b1) == len_q);

  // Extra carry bit detects overflow so the accumulator can clamp at all-ones.
  assign hit       = (dec_out == exp_bit);
  assign score_sum = {1'b0, score} + (exp_bit ? W_HIT1 : W_HIT0);
  assign score_upd = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl <= IDLE;
    end else begin
      ctrl <= ctrl_nxt;
    end
  end

  always_comb begin
    ctrl_nxt = ctrl;
    case (ctrl)
      IDLE: begin
        if (load) begin
          ctrl_nxt = (seq_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (accept && last_bit) begin
          ctrl_nxt = DONE;
        end
      end
      DONE:    ctrl_nxt = IDLE;
      default: ctrl_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chrom_q   <= '0;
      len_q     <= '0;
      count     <= '0;
      fsm_state <= '0;
      score     <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_state <= '0;
    end else begin
      out_valid <= 1'b0;
      if (load) begin
        chrom_q   <= chrom_data;
        len_q     <= seq_len;
        count     <= '0;
        fsm_state <= '0;
        score     <= '0;
      end else if (accept) begin
        fsm_state <= dec_state;
        out_bit   <= dec_out;
        out_state <= dec_state;
        out_valid <= 1'b1;
        count     <= count + 1'b1;
        if (hit) begin
          score <= score_upd;
        end
      end
    end
  end

endmodule

// File: tb/tb_ga_chrom_fsm_exec.sv
// tb/tb_ga_chrom_fsm_exec.sv - self-checking bench for ga_chrom_fsm_exec
module tb_ga_chrom_fsm_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chrom_valid;
  logic [23:0] chrom_data;
  logic [7:0]  seq_len;
  logic        in_valid;
  logic        in_bit;
  logic        exp_bit;

  logic        chrom_ready, in_ready, out_valid, out_bit, done;
  logic [1:0]  out_state;
  logic [11:0] score;

  logic        s_chrom_ready, s_in_ready, s_out_valid, s_out_bit, s_done;
  logic [1:0]  s_out_state;
  logic [3:0]  s_score;

  always #5 clk = ~clk;

  ga_chrom_fsm_exec dut (
    .clk(clk), .rst_n(rst_n), .chrom_valid(chrom_valid), .chrom_ready(chrom_ready),
    .chrom_data(chrom_data), .seq_len(seq_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .exp_bit(exp_bit), .out_valid(out_valid), .out_bit(out_bit),
    .out_state(out_state), .done(done), .score(score)
  );

  ga_chrom_fsm_exec #(.SCORE_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .chrom_valid(chrom_valid), .chrom_ready(s_chrom_ready),
    .chrom_data(chrom_data), .seq_len(seq_len), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_bit(in_bit), .exp_bit(exp_bit), .out_valid(s_out_valid), .out_bit(s_out_bit),
    .out_state(s_out_state), .done(s_done), .score(s_score)
  );

  int checks = 0;
  int failures = 0;

  bit in_q[$];
  bit exp_q[$];
  bit ob_q[$];
  int os_q[$];
  int sc_q[$];
  int ssc_q[$];
  int acc_cyc[$];
  int ov_cyc[$];
  int done_cnt, done_cyc, done_with_ov, after_done_ok, timed_out;
  int fin_score, fin_sscore;
  int stall_pct = 0;
  int gap = 0;

  bit m_bit[$];
  int m_state[$];
  int m_score[$];
  int m_sscore[$];

  // Reference: walk the transition table straight from the chromosome value.
  task automatic model(input logic [23:0] ch);
    int s;
    int sc;
    int ssc;
    s = 0; sc = 0; ssc = 0;
    m_bit.delete(); m_state.delete(); m_score.delete(); m_sscore.delete();
    foreach (in_q[i]) begin
      int e;
      int g;
      int w;
      e = s * 2 + int'(in_q[i]);
      g = int'((ch >> (4 * e)) & 24'hF);
      s = (g % 8) % 3;
      if ((g / 8) == int'(exp_q[i])) begin
        w = exp_q[i] ? 3 : 1;
        sc = (sc + w > 4095) ? 4095 : sc + w;
        ssc = (ssc + w > 15) ? 15 : ssc + w;
      end
      m_bit.push_back(bit'(g / 8));
      m_state.push_back(s);
      m_score.push_back(sc);
      m_sscore.push_back(ssc);
    end
  endtask

  // Loads a chromosome, streams in_q/exp_q, records every observation.
  task automatic run_seq(input logic [23:0] ch, input int len);
    int idx;
    int cyc;
    int gap_cnt;
    bit found;
    ob_q.delete(); os_q.delete(); sc_q.delete(); ssc_q.delete();
    acc_cyc.delete(); ov_cyc.delete();
    done_cnt = 0; done_cyc = -1; done_with_ov = 0; after_done_ok = 0; timed_out = 0;
    fin_score = -1; fin_sscore = -1;
    @(negedge clk);
    chrom_data = ch; seq_len = len[7:0]; chrom_valid = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chrom_valid = 1'b0; chrom_data = 24'($urandom); seq_len = 8'($urandom);
    idx = 0; gap_cnt = 0; found = 0;
    for (cyc = 1; cyc < 3000 && !found; cyc++) begin
      if (out_valid) begin
        ob_q.push_back(out_bit); os_q.push_back(int'(out_state));
        sc_q.push_back(int'(score)); ssc_q.push_back(int'(s_score));
        ov_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++; done_cyc = cyc; done_with_ov = int'(out_valid);
        fin_score = int'(score); fin_sscore = int'(s_score);
        found = 1;
      end else begin
        if (idx < in_q.size() && gap_cnt == 0 && $urandom_range(99) >= stall_pct) begin
          in_valid = 1'b1; in_bit = in_q[idx]; exp_bit = exp_q[idx];
          if (in_ready) begin
            acc_cyc.push_back(cyc); idx++; gap_cnt = gap;
          end
        end else begin
          if (gap_cnt > 0) gap_cnt--;
          in_valid = 1'b0; in_bit = 1'($urandom); exp_bit = 1'($urandom);
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    if (!found) timed_out = 1;
    @(negedge clk);
    after_done_ok = int'(done == 1'b0 && chrom_ready == 1'b1 && out_valid == 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; chrom_valid = 1'b0; chrom_data = '0; seq_len = '0;
    in_valid = 1'b0; in_bit = 1'b0; exp_bit = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({chrom_ready, in_ready, out_valid, out_bit, out_state, done, score} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0}) begin
      failures++;
      $display("FAIL reset_values: got rdy=%b inrdy=%b ov=%b ob=%b os=%0d done=%b score=%0d, want 1 0 0 0 0 0 0",
               chrom_ready, in_ready, out_valid, out_bit, out_state, done, score);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_known_good();
    bit eb[5] = '{0, 0, 0, 0, 1};
    int es[5] = '{0, 0, 1, 2, 1};
    in_q = '{0, 0, 1, 0, 1}; exp_q = '{0, 0, 0, 0, 1};
    stall_pct = 0; gap = 0;
    run_seq(24'h901210, 5);
    checks++;
    if (timed_out !== 0 || ob_q.size() !== 5) begin
      failures++;
      $display("FAIL known_good_count: got %0d outputs timeout=%0d, want 5 timeout=0", ob_q.size(), timed_out);
    end
    for (int i = 0; i < 5 && i < ob_q.size(); i++) begin
      checks++;
      if (ob_q[i] !== eb[i] || os_q[i] !== es[i]) begin
        failures++;
        $display("FAIL known_good_out[%0d]: got bit=%0d state=%0d, want bit=%0d state=%0d", i, ob_q[i], os_q[i], eb[i], es[i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_with_ov !== 1 || fin_score !== 7 || after_done_ok !== 1) begin
      failures++;
      $display("FAIL known_good_done: got done=%0d with_ov=%0d score=%0d idle_after=%0d, want 1 1 7 1",
               done_cnt, done_with_ov, fin_score, after_done_ok);
    end
  endtask

  task automatic test_zero_chrom();
    in_q = '{0, 0, 1, 0, 1}; exp_q = '{0, 0, 0, 0, 1};
    stall_pct = 0; gap = 0;
    run_seq(24'h000000, 5);
    checks++;
    if (ob_q.size() !== 5 || ob_q.sum() with (int'(item)) !== 0 || os_q.sum() !== 0) begin
      failures++;
      $display("FAIL zero_chrom_outputs: got n=%0d ones=%0d statesum=%0d, want n=5 ones=0 statesum=0",
               ob_q.size(), ob_q.sum() with (int'(item)), os_q.sum());
    end
    checks++;
    if (fin_score !== 4 || done_cnt !== 1) begin
      failures++;
      $display("FAIL zero_chrom_score: got score=%0d done=%0d, want score=4 done=1", fin_score, done_cnt);
    end
  endtask

  task automatic test_modulo_wrap();
    in_q = '{0, 0}; exp_q = '{0, 0};
    stall_pct = 0; gap = 0;
    run_seq(24'h000007, 2);
    checks++;
    if (ob_q.size() !== 2 || os_q[0] !== 1 || os_q[1] !== 0 || ob_q[0] !== 1'b0 || ob_q[1] !== 1'b0) begin
      failures++;
      $display("FAIL modulo_wrap: got n=%0d states=%0d,%0d bits=%0d,%0d, want n=2 states=1,0 bits=0,0",
               ob_q.size(), os_q.size() > 0 ? os_q[0] : -1, os_q.size() > 1 ? os_q[1] : -1,
               ob_q.size() > 0 ? ob_q[0] : 0, ob_q.size() > 1 ? ob_q[1] : 0);
    end
  endtask

  task automatic test_stall();
    int es[5] = '{0, 0, 1, 2, 1};
    in_q = '{0, 0, 1, 0, 1}; exp_q = '{0, 0, 0, 0, 1};
    stall_pct = 0; gap = 3;
    run_seq(24'h901210, 5);
    gap = 0;
    checks++;
    if (ob_q.size() !== 5 || acc_cyc.size() !== 5 || fin_score !== 7 || done_with_ov !== 1) begin
      failures++;
      $display("FAIL stall_summary: got outs=%0d accepts=%0d score=%0d with_ov=%0d, want 5 5 7 1",
               ob_q.size(), acc_cyc.size(), fin_score, done_with_ov);
    end
    for (int i = 0; i < 5 && i < ov_cyc.size() && i < acc_cyc.size(); i++) begin
      checks++;
      if (ov_cyc[i] !== acc_cyc[i] + 1 || os_q[i] !== es[i]) begin
        failures++;
        $display("FAIL stall_out[%0d]: got cycle=%0d state=%0d, want cycle=%0d state=%0d",
                 i, ov_cyc[i], os_q[i], acc_cyc[i] + 1, es[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    in_q.delete(); exp_q.delete();
    stall_pct = 0; gap = 0;
    run_seq(24'h901210, 0);
    checks++;
    if (done_cyc !== 1 || done_cnt !== 1 || ob_q.size() !== 0 || fin_score !== 0 || after_done_ok !== 1) begin
      failures++;
      $display("FAIL zero_len: got done_cyc=%0d done=%0d outs=%0d score=%0d idle_after=%0d, want 1 1 0 0 1",
               done_cyc, done_cnt, ob_q.size(), fin_score, after_done_ok);
    end
  endtask

  task automatic test_saturation();
    int ess[6] = '{3, 6, 9, 12, 15, 15};
    in_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      in_q.push_back(1'($urandom)); exp_q.push_back(1'b1);
    end
    stall_pct = 20; gap = 0;
    run_seq(24'h999999, 6);
    stall_pct = 0;
    checks++;
    if (ssc_q.size() !== 6 || fin_score !== 18) begin
      failures++;
      $display("FAIL saturation_summary: got outs=%0d wide_score=%0d, want 6 18", ssc_q.size(), fin_score);
    end
    for (int i = 0; i < 6 && i < ssc_q.size(); i++) begin
      checks++;
      if (ssc_q[i] !== ess[i]) begin
        failures++;
        $display("FAIL saturation_score[%0d]: got %0d, want %0d", i, ssc_q[i], ess[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    dones = 0;
    @(negedge clk);
    chrom_data = 24'h901210; seq_len = 8'd5; chrom_valid = 1'b1;
    @(negedge clk);
    chrom_valid = 1'b0; in_valid = 1'b1; in_bit = 1'b0; exp_bit = 1'b0;
    @(negedge clk);
    in_bit = 1'b1; exp_bit = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({chrom_ready, in_ready, out_valid, out_bit, out_state, done, score} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0}) begin
      failures++;
      $display("FAIL reset_mid_run: got rdy=%b inrdy=%b ov=%b ob=%b os=%0d done=%b score=%0d, want 1 0 0 0 0 0 0",
               chrom_ready, in_ready, out_valid, out_bit, out_state, done, score);
    end
    for (int i = 0; i < 3; i++) begin
      if (done) dones++;
      if (i == 1) rst_n = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d done pulses, want 0", dones);
    end
    in_q = '{0, 0, 1, 0, 1}; exp_q = '{0, 0, 0, 0, 1};
    run_seq(24'h901210, 5);
    checks++;
    if (fin_score !== 7 || done_cnt !== 1) begin
      failures++;
      $display("FAIL reset_reload_score: got score=%0d done=%0d, want 7 1", fin_score, done_cnt);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [23:0] ch;
      int len;
      ch = 24'($urandom);
      len = $urandom_range(16, 1);
      in_q.delete(); exp_q.delete();
      for (int i = 0; i < len; i++) begin
        in_q.push_back(1'($urandom)); exp_q.push_back(1'($urandom));
      end
      stall_pct = 30; gap = $urandom_range(2);
      model(ch);
      run_seq(ch, len);
      checks++;
      if (ob_q.size() !== len || done_cnt !== 1 || fin_score !== m_score[len-1] || fin_sscore !== m_sscore[len-1]) begin
        failures++;
        $display("FAIL random_run[%0d]: chrom=%h got outs=%0d done=%0d score=%0d sat=%0d, want %0d 1 %0d %0d",
                 it, ch, ob_q.size(), done_cnt, fin_score, fin_sscore, len, m_score[len-1], m_sscore[len-1]);
      end
      for (int i = 0; i < len && i < ob_q.size(); i++) begin
        checks++;
        if (ob_q[i] !== m_bit[i] || os_q[i] !== m_state[i] || sc_q[i] !== m_score[i] || ov_cyc[i] !== acc_cyc[i] + 1) begin
          failures++;
          $display("FAIL random_out[%0d.%0d]: got bit=%0d state=%0d score=%0d lat=%0d, want %0d %0d %0d 1",
                   it, i, ob_q[i], os_q[i], sc_q[i], ov_cyc[i] - acc_cyc[i], m_bit[i], m_state[i], m_score[i]);
        end
      end
    end
    stall_pct = 0; gap = 0;
  endtask

  initial begin
    test_reset();
    test_known_good();
    test_zero_chrom();
    test_modulo_wrap();
    test_stall();
    test_zero_len();
    test_saturation();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
